ram_port_arbiter: RTL

Two-requester arbiter for the coprocessor's single-port, fully synchronous local RAM. It lets two clients share the one RAM port: client A is the AXI-Stream input loader, and client B is the compute engine or output drainer. It grants at most one access per cycle using round-robin priority, with an optional lock for uninterrupted bursts. It routes the 1-cycle-latency read data back to the client that issued the read.

---
 rtl/ram_port_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter with burst lock for a single-port synchronous RAM
//
// Shares one RAM port between client A (stream loader) and client B (compute /
// drain). At most one access is granted per cycle. With no owner, a tie goes to
// the client not granted most recently. A client that completes a transfer with
// its lock set becomes owner until it completes a transfer with lock clear.
// Read data returns one cycle after the accepted read, flagged per client.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   a_* / b_*                      client request (valid/ready/we/lock/addr/wdata)
//                                  and response (rvalid/rdata)
//   ram_write_en, ram_read_en      RAM strobes (never both high)
//   ram_write_address/_data_in     RAM write side
//   ram_read_address               RAM read address
//   ram_read_data_out              RAM registered read output
module ram_port_arbiter #(
  parameter int width      = 8,
  parameter int depth_bits = 2
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [depth_bits-1:0] a_addr,
  input  logic [width-1:0]      a_wdata,
  output logic                  a_rvalid,
  output logic [width-1:0]      a_rdata,

  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [depth_bits-1:0] b_addr,
  input  logic [width-1:0]      b_wdata,
  output logic                  b_rvalid,
  output logic [width-1:0]      b_rdata,

  output logic                  ram_write_en,
  output logic                  ram_read_en,
  output logic [depth_bits-1:0] ram_write_address,
  output logic [depth_bits-1:0] ram_read_address,
  output logic [width-1:0]      ram_write_data_in,
  input  logic [width-1:0]      ram_read_data_out
);

  typedef enum logic [1:0] {
    ARB,
    OWN_A,
    OWN_B
  } state_t;

  state_t state;
  logic   last_b;      // 1 = B was granted most recently
  logic   a_rvalid_q;
  logic   b_rvalid_q;
  logic   grant_a;
  logic   grant_b;

  // Grant decision. Ready is combinational on same-cycle valid.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      case (state)
        ARB: begin
          if (a_valid && (!b_valid || last_b)) grant_a = 1'b1;
          else if (b_valid)                    grant_b = 1'b1;
        end
        OWN_A:   grant_a = a_valid;
        OWN_B:   grant_b = b_valid;
        default: begin
          grant_a = 1'b0;
          grant_b = 1'b0;
        end
      endcase
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // RAM port mux; everything idles at zero when nothing is granted.
  always_comb begin
    ram_write_en      = 1'b0;
    ram_read_en       = 1'b0;
    ram_write_address = '0;
    ram_read_address  = '0;
    ram_write_data_in = '0;
    if (grant_a) begin
      if (a_we) begin
        ram_write_en      = 1'b1;
        ram_write_address = a_addr;
        ram_write_data_in = a_wdata;
      end else begin
        ram_read_en      = 1'b1;
        ram_read_address = a_addr;
      end
    end else if (grant_b) begin
      if (b_we) begin
        ram_write_en      = 1'b1;
        ram_write_address = b_addr;
        ram_write_data_in = b_wdata;
      end else begin
        ram_read_en      = 1'b1;
        ram_read_address = b_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      last_b     <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= grant_a & ~a_we;
      b_rvalid_q <= grant_b & ~b_we;
      if (grant_a) begin
        last_b <= 1'b0;
        case (state)
          ARB:     if (a_lock)  state <= OWN_A;
          OWN_A:   if (!a_lock) state <= ARB;
          default: state <= state;
        endcase
      end else if (grant_b) begin
        last_b <= 1'b1;
        case (state)
          ARB:     if (b_lock)  state <= OWN_B;
          OWN_B:   if (!b_lock) state <= ARB;
          default: state <= state;
        endcase
      end
    end
  end

  // Masking with reset hides a read that was in flight when reset arrived,
  // so no stale pulse is seen during or after reset.
  assign a_rvalid = a_rvalid_q & ~reset;
  assign b_rvalid = b_rvalid_q & ~reset;
  assign a_rdata  = ram_read_data_out;
  assign b_rdata  = ram_read_data_out;

endmodule
